// File: rtl/frame_serializer_pkg.sv
// Shared types and constants for the telemetry frame serializer.
package frame_serializer_pkg;

  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned WORDS_DEF  = 8;
  localparam int unsigned RD_LAT_DEF = 2;
  localparam int unsigned AW_DEF     = 3;
  localparam int unsigned SYNC_BITS  = 16;
  localparam logic [SYNC_BITS-1:0] SYNC_DEF = 16'hF3A0;
  localparam int unsigned FRAME_BITS = SYNC_BITS + WORDS_DEF * WORD_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/frame_serializer_if.sv
// Word-store read port plus serial line outputs of the frame serializer.
interface frame_serializer_if
  import frame_serializer_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned AW     = AW_DEF
);
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              txd;
  logic              bit_stb;
  logic              frame_sync;
  logic              busy;
  logic              ovr;

  modport master (
    output rd_en, rd_addr, txd, bit_stb, frame_sync, busy, ovr,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, txd, bit_stb, frame_sync, busy, ovr,
    output rd_data
  );
endinterface

// File: rtl/frame_serializer_edge_tick.sv
// Registered rising-edge detector for a divided-clock level sampled in the clk80 domain.
module edge_tick (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      prev <= level;
      tick <= level & ~prev;
    end
  end
endmodule

// File: rtl/frame_serializer.sv
// Serializes one frame (sync marker + WORDS data words, MSB first) per frame tick,
// one bit per bit tick, fetching words through a fixed-latency read port.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int unsigned          WORD_W = WORD_W_DEF,
  parameter int unsigned          WORDS  = WORDS_DEF,
  parameter logic [SYNC_BITS-1:0] SYNC   = SYNC_DEF,
  parameter int unsigned          RD_LAT = RD_LAT_DEF,
  parameter int unsigned          AW     = AW_DEF
) (
  input  logic                clk80,
  input  logic                reset,
  input  logic                clk640k,
  input  logic                clk8k,
  frame_serializer_if.master  bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [AW-1:0]    LAST_WORD = AW'(WORDS - 1);

  logic bit_tick, frame_tick;

  edge_tick u_bit_edge   (.clk(clk80), .reset(reset), .level(clk640k), .tick(bit_tick));
  edge_tick u_frame_edge (.clk(clk80), .reset(reset), .level(clk8k),   .tick(frame_tick));

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic                ovr_q, ovr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]       word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic                txd_q, txd_d;
  logic                bit_stb_q, bit_stb_d;
  logic                fsync_q, fsync_d;
  logic                busy_q, busy_d;
  logic                rd_en_q, rd_en_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;

  logic             field_end, frame_end, start;
  logic [CNT_W-1:0] sync_idx;

  assign field_end = (state_q == ST_DATA) && (bit_cnt_q == WORD_LAST);
  assign frame_end = field_end && (word_cnt_q == LAST_WORD);
  assign start     = bit_tick && pending_q && ((state_q == ST_IDLE) || frame_end);
  assign sync_idx  = CNT_W'(SYNC_BITS - 2) - bit_cnt_q;

  // Next-state and output decode; a frame start overrides the end-of-frame return to idle.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ovr_d      = ovr_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    fsync_d    = fsync_q;
    busy_d     = busy_q;
    rd_addr_d  = rd_addr_q;
    bit_stb_d  = 1'b0;
    rd_en_d    = 1'b0;
    rd_pipe_d  = RD_LAT'({rd_pipe_q, rd_en_q});
    hold_d     = rd_pipe_q[RD_LAT-1] ? bus.rd_data : hold_q;

    if (frame_tick) begin
      pending_d = 1'b1;
      if (pending_q) ovr_d = 1'b1;
    end else if (start) begin
      pending_d = 1'b0;
    end

    if (bit_tick) begin
      case (state_q)
        ST_SYNC: begin
          bit_stb_d = 1'b1;
          if (bit_cnt_q == SYNC_LAST) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            shreg_d    = hold_q << 1;
            txd_d      = hold_q[WORD_W-1];
            fsync_d    = 1'b0;
            rd_en_d    = (WORDS > 1);
            rd_addr_d  = AW'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            txd_d     = SYNC[sync_idx];
          end
        end
        ST_DATA: begin
          bit_stb_d = 1'b1;
          if (!field_end) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            txd_d     = shreg_q[WORD_W-1];
            shreg_d   = shreg_q << 1;
          end else if (!frame_end) begin
            word_cnt_d = word_cnt_q + AW'(1);
            bit_cnt_d  = '0;
            shreg_d    = hold_q << 1;
            txd_d      = hold_q[WORD_W-1];
            rd_en_d    = (word_cnt_q + AW'(1)) != LAST_WORD;
            rd_addr_d  = word_cnt_q + AW'(2);
          end else begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            txd_d      = 1'b0;
            fsync_d    = 1'b0;
            busy_d     = 1'b0;
          end
        end
        default: ;
      endcase

      if (start) begin
        state_d    = ST_SYNC;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        txd_d      = SYNC[SYNC_BITS-1];
        fsync_d    = 1'b1;
        busy_d     = 1'b1;
        bit_stb_d  = 1'b1;
        rd_en_d    = 1'b1;
        rd_addr_d  = '0;
      end
    end
  end

  always_ff @(posedge clk80 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      ovr_q      <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      hold_q     <= '0;
      rd_pipe_q  <= '0;
      txd_q      <= 1'b0;
      bit_stb_q  <= 1'b0;
      fsync_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ovr_q      <= ovr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      rd_pipe_q  <= rd_pipe_d;
      txd_q      <= txd_d;
      bit_stb_q  <= bit_stb_d;
      fsync_q    <= fsync_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.txd        = txd_q;
  assign bus.bit_stb    = bit_stb_q;
  assign bus.frame_sync = fsync_q;
  assign bus.busy       = busy_q;
  assign bus.ovr        = ovr_q;
endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: frame content, read timing, back-to-back, overrun, reset.
module tb_frame_serializer;
  import frame_serializer_pkg::*;

  localparam int BIT_P  = 42;
  localparam int RD_LAT = 2;
  localparam int BUDGET = 3 * FRAME_BITS * BIT_P;

  logic clk80 = 1'b0, reset = 1'b0, clk640k = 1'b0, clk8k = 1'b0;

  frame_serializer_if bus ();

  frame_serializer #(.RD_LAT(RD_LAT)) dut (
    .clk80(clk80), .reset(reset), .clk640k(clk640k), .clk8k(clk8k), .bus(bus)
  );

  always #5 clk80 = ~clk80;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, ph = 0, c8_cnt = 0, req8k_ph = 0;
  bit run640 = 1'b0, req8k = 1'b0;
  int rise8_cyc = 0, rise640_cyc = -100;
  logic q_bits[$];
  logic q_fs[$];
  int   q_addr[$];
  int   first_stb = -1, end_cnt = 0, lat_err = 0;
  logic end_txd = 1'b0, end_fs = 1'b0;
  int   sv_v[0:4];
  int   sv_a[0:4];

  // Word store model, line monitor and divided-clock generator, all on the falling edge.
  always @(negedge clk80) begin
    cyc++;
    for (int i = 4; i > 0; i--) begin sv_v[i] = sv_v[i-1]; sv_a[i] = sv_a[i-1]; end
    sv_v[0] = (reset && bus.rd_en) ? 1 : 0;
    sv_a[0] = int'(bus.rd_addr);
    if (sv_v[RD_LAT] != 0) bus.rd_data = 8'(8'h10 + sv_a[RD_LAT]);
    else                   bus.rd_data = 8'($urandom);
    if (reset) begin
      if (bus.rd_en) q_addr.push_back(int'(bus.rd_addr));
      if (bus.bit_stb) begin
        if (cyc - rise640_cyc != 2) lat_err++;
        if (first_stb < 0) first_stb = cyc;
        if (bus.busy) begin
          q_bits.push_back(bus.txd);
          q_fs.push_back(bus.frame_sync);
        end else begin
          end_cnt++;
          end_txd = bus.txd;
          end_fs  = bus.frame_sync;
        end
      end
    end
    if (run640) begin
      ph = (ph == BIT_P - 1) ? 0 : ph + 1;
      clk640k = (ph < BIT_P / 2);
      if (ph == 0) rise640_cyc = cyc;
    end
    if (req8k && ph == req8k_ph) begin
      clk8k = 1'b1; c8_cnt = 20; req8k = 1'b0; rise8_cyc = cyc;
    end else if (c8_cnt > 0) begin
      c8_cnt--;
      if (c8_cnt == 0) clk8k = 1'b0;
    end
  end

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    q_bits.delete(); q_fs.delete(); q_addr.delete();
    first_stb = -1; end_cnt = 0; lat_err = 0; end_txd = 1'b0; end_fs = 1'b0;
  endtask

  task automatic request(input int p);
    @(posedge clk80);
    req8k_ph = p;
    req8k    = 1'b1;
  endtask

  task automatic wait_fired(input string name);
    int k = 0;
    while (req8k && k < 4 * BIT_P) begin @(posedge clk80); k++; end
    if (req8k) begin n_chk++; n_fail++; $display("FAIL %s: clk8k request never issued", name); end
  endtask

  task automatic wait_bits(input int n, input string name);
    int k = 0;
    while (q_bits.size() < n && k < BUDGET) begin @(posedge clk80); k++; end
    if (q_bits.size() < n) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout, got %0d bits expected %0d", name, q_bits.size(), n);
    end
  endtask

  task automatic wait_end(input string name);
    int k = 0;
    while (end_cnt == 0 && k < BUDGET) begin @(posedge clk80); k++; end
    if (end_cnt == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for frame end, got %0d expected 1", name, end_cnt);
    end
  endtask

  task automatic check_stream(input string tag, input int nbits, input logic [159:0] exp_bits,
                              input logic [159:0] exp_fs, input logic [47:0] exp_addr,
                              input int nwords);
    logic [159:0] b = '0;
    logic [159:0] f = '0;
    logic [47:0]  a = '0;
    foreach (q_bits[i]) begin b = {b[158:0], q_bits[i]}; f = {f[158:0], q_fs[i]}; end
    foreach (q_addr[i]) a = {a[44:0], 3'(q_addr[i])};
    chk_int({tag, " bit count"}, q_bits.size(), nbits);
    chk_vec({tag, " txd stream"}, b, exp_bits);
    chk_vec({tag, " frame_sync"}, f, exp_fs);
    chk_int({tag, " rd_en count"}, q_addr.size(), nwords);
    chk_vec({tag, " rd_addr seq"}, 160'(a), 160'(exp_addr));
    chk_int({tag, " end strobes"}, end_cnt, 1);
    chk_int({tag, " end txd/fsync"}, int'({end_txd, end_fs}), 0);
    chk_int({tag, " stb latency errs"}, lat_err, 0);
  endtask

  typedef struct {
    int          rise_ph;
    int          exp_delay;
    logic [79:0] exp_bits;
    logic [79:0] exp_fs;
    logic [23:0] exp_addr;
  } vec_t;

  vec_t vt[4];

  localparam logic [159:0] TWO_FRAMES = 160'hF3A0_1011121314151617_F3A0_1011121314151617;
  localparam logic [159:0] TWO_FS     = 160'hFFFF_0000000000000000_FFFF_0000000000000000;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] acc;
    string tag;
    vt[0] = '{10, 34, 80'hF3A0_1011121314151617, 80'hFFFF_0000000000000000, 24'o01234567};
    vt[1] = '{0,  44, 80'hF3A0_1011121314151617, 80'hFFFF_0000000000000000, 24'o01234567};
    vt[2] = '{41, 3,  80'hF3A0_1011121314151617, 80'hFFFF_0000000000000000, 24'o01234567};
    vt[3] = '{1,  43, 80'hF3A0_1011121314151617, 80'hFFFF_0000000000000000, 24'o01234567};

    // Reset held while both divided clocks toggle.
    run640 = 1'b1;
    request(5);
    acc = '0;
    repeat (200) begin
      @(negedge clk80);
      acc = acc | {bus.txd, bus.bit_stb, bus.busy, bus.ovr, bus.rd_en, bus.frame_sync, 1'b0};
    end
    chk_int("reset outputs held", int'(acc), 0);
    chk_int("reset ovr", int'(bus.ovr), 0);
    chk_int("reset txd", int'(bus.txd), 0);
    @(posedge clk80); #2 reset = 1'b1;
    @(posedge clk80); clear_mon();
    repeat (3 * BIT_P) @(posedge clk80);
    chk_int("no frame without request", first_stb, -1);

    // Single frames at several clk8k phases relative to the bit clock.
    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("vec%0d", i);
      @(posedge clk80); clear_mon();
      request(vt[i].rise_ph);
      wait_end(tag);
      chk_int({tag, " start delay"}, first_stb - rise8_cyc, vt[i].exp_delay);
      check_stream(tag, 80, 160'(vt[i].exp_bits), 160'(vt[i].exp_fs), 48'(vt[i].exp_addr), 8);
      repeat (2 * BIT_P) @(negedge clk80);
      chk_int({tag, " idle line"}, int'({bus.txd, bus.busy, bus.frame_sync, bus.ovr}), 0);
    end

    // Back-to-back: next request during bit 70.
    @(posedge clk80); clear_mon();
    request(10);
    wait_bits(70, "b2b");
    request(20);
    wait_end("b2b");
    check_stream("b2b", 160, TWO_FRAMES, TWO_FS, 48'o0123456701234567, 16);
    chk_int("b2b ovr", int'(bus.ovr), 0);

    // Overrun: two requests inside one frame.
    @(posedge clk80); clear_mon();
    request(10);
    wait_bits(20, "ovr");
    request(5);
    wait_fired("ovr first");
    wait_bits(30, "ovr");
    @(negedge clk80);
    chk_int("ovr after one queued", int'(bus.ovr), 0);
    wait_bits(40, "ovr");
    request(5);
    wait_fired("ovr second");
    repeat (4) @(negedge clk80);
    chk_int("ovr set", int'(bus.ovr), 1);
    wait_end("ovr");
    check_stream("ovr", 160, TWO_FRAMES, TWO_FS, 48'o0123456701234567, 16);
    repeat (3 * BIT_P) @(negedge clk80);
    chk_int("ovr sticky", int'(bus.ovr), 1);

    // Reset during word 3, then a clean frame.
    @(posedge clk80); clear_mon();
    request(10);
    wait_bits(43, "midreset");
    @(negedge clk80); #1 reset = 1'b0;
    #1;
    chk_int("midreset line", int'({bus.txd, bus.busy, bus.frame_sync, bus.bit_stb, bus.rd_en}), 0);
    chk_int("midreset ovr", int'(bus.ovr), 0);
    repeat (5) @(posedge clk80);
    #2 reset = 1'b1;
    @(posedge clk80); clear_mon();
    repeat (2 * BIT_P) @(posedge clk80);
    chk_int("midreset no stale frame", first_stb, -1);
    request(10);
    wait_end("post reset");
    chk_int("post reset start delay", first_stb - rise8_cyc, 34);
    check_stream("post reset", 80, 160'(vt[0].exp_bits), 160'(vt[0].exp_fs), 48'(vt[0].exp_addr), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Consumes the divided clocks from the clock-divider stage (640 kHz bit clock, 8 kHz frame clock) as level inputs in the clk80 domain.
- Builds one telemetry frame per 8 kHz period: a 16-bit sync marker followed by WORDS data words, MSB first, at one bit per 640 kHz period.
- Fetches data words through a fixed-latency read port from the upstream word store.
- Drives a serial line plus strobes to the line driver.

Parameters:
- WORD_W, 8: data word width.
- WORDS, 8: data words per frame (16 + 8*8 = 80 bits = 640k/8k).
- SYNC, 16'hF3A0: sync marker, sent MSB first.
- RD_LAT, 2: clk80 cycles from rd_en to valid rd_data; legal range 1..4.
- AW, 3: rd_addr width, ceil(log2(WORDS)).

Ports:
- clk80 in 1: system clock, 80.64 MHz.
- reset in 1: asynchronous, active-low reset.
- clk640k in 1: bit-rate clock level from the divider, synchronous to clk80.
- clk8k in 1: frame-rate clock level from the divider, synchronous to clk80.
- rd_en out 1: one-cycle word read request.
- rd_addr out AW: word index 0..WORDS-1.
- rd_data in WORD_W: word data, valid exactly RD_LAT cycles after rd_en.
- txd out 1: serial data.
- bit_stb out 1: one-cycle pulse in the cycle txd takes a new bit.
- frame_sync out 1: high while a sync bit is on txd.
- busy out 1: high while a frame is on the line.
- ovr out 1: sticky frame-overrun flag.

Behaviour:
- Reset (async, reset=0): all outputs 0; state IDLE; pending=0; edge registers=0; counters=0.
- Edge detect: registered copies of clk640k and clk8k.
  - bit_tick = clk640k & ~prev640.
  - frame_tick = clk8k & ~prev8.
  - Both are single clk80 pulses, used one cycle after the level rises.
- frame_tick sets pending.
  - If pending is already 1 when frame_tick fires: set ovr=1. pending stays 1 and frames are not queued deeper.
  - ovr clears only on reset.
- FSM states: IDLE, SYNC, DATA.
- IDLE:
  - txd=0, busy=0.
  - On bit_tick with pending=1: clear pending, go to SYNC, drive SYNC[15] on txd, bit_stb=1, frame_sync=1, busy=1.
  - Also issue rd_en with rd_addr=0 in the same cycle.
  - frame_tick and bit_tick in the same cycle: pending is set this cycle, and the frame starts at the next bit_tick, not this one.
- SYNC:
  - Each bit_tick shifts out the next marker bit.
  - After SYNC[0] has been on the line, the next bit_tick goes to DATA and drives the MSB of word 0.
- DATA:
  - The word shift register loads from the holding register at each word's first bit.
  - At that same bit_tick, rd_en is issued for word k+1 (suppressed when k=WORDS-1).
  - rd_data is captured into the holding register exactly RD_LAT cycles after rd_en. The bit period is 126 cycles, so the capture always completes before the word boundary.
- End of frame: after the LSB of word WORDS-1, the next bit_tick either
  - starts a new frame (enter SYNC exactly as from IDLE) if pending=1, giving back-to-back frames with no gap; or
  - returns to IDLE with txd=0, busy=0, bit_stb=1.
- Outputs are registered. txd, bit_stb and frame_sync change together, one cycle after the bit_tick cycle, i.e. two cycles after clk640k rises.
- Between bit_ticks all outputs hold; bit_stb=0.
- Counters:
  - Bit-in-field counter 0..15 for sync and 0..WORD_W-1 for data.
  - Word counter 0..WORDS-1; it ends the frame at WORDS-1 and does not wrap.
- Reset mid-frame: the frame is abandoned immediately and txd=0. A pending rd_en capture is discarded. The next frame starts from SYNC.
- clk640k stuck: the FSM holds state with no timeout.

Decomposition:
- Shared package holds the state enum (IDLE/SYNC/DATA), the SYNC default and the frame-length constant FRAME_BITS = 16 + WORDS*WORD_W.
- One natural sub-module: edge_tick, a registered rising-edge detector instanced twice, for clk640k and clk8k.

Test Plan:
- Reset: hold reset=0 while toggling the clocks -> txd=0, bit_stb=0, busy=0, ovr=0, rd_en=0.
- Single frame: one clk8k rise, clk640k every 126 cycles, rd_data = 8'h10+addr -> txd carries F3A0 then 10,11,...,17 MSB first. That is 80 bit_stb pulses with frame_sync high for the first 16. Then busy=0, txd=0.
- Read timing: on each word start -> exactly one rd_en with addr k+1; rd_data is sampled RD_LAT=2 cycles later. Bench changes rd_data on other cycles with no effect. Exactly 8 rd_en per frame.
- Back-to-back: next clk8k rise during bit 70 -> the new frame's SYNC[15] appears on the bit_tick after word-7 LSB, with no idle bit and busy staying 1.
- Coincident ticks and overrun: clk8k and clk640k rise in the same cycle -> the frame starts one bit later. Two clk8k rises within one frame -> ovr=1 and stays 1.
- Reset mid-frame: reset during word 3 -> txd=0 immediately. A later clk8k rise starts a clean frame from F3A0 with addr 0.
